cmd_frame_tx: RTL and testbench

// Command frame encoder. Turns a single-beat command request into the 8-byte command frame
// EB 90 SEQ ADDR CMD CHK 09 D7 and pushes it byte by byte into the UART transmit FIFO.
// CHK makes SEQ+ADDR+CMD+CHK == 8'h00 (mod 256). This is the same frame format the

---
 rtl/cmd_frame_tx.sv | 167 ++++++++++++++++
 tb/tb_cmd_frame_tx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cmd_frame_tx.sv
// Command frame encoder: EB 90 SEQ ADDR CMD CHK 09 D7 pushed byte by byte into the UART TX FIFO.
// Optional sequence counter enabled by defining CMD_TX_SEQ_EN (default: SEQ byte fixed at 8'h00).
`ifndef UART_FIFO_COUNTER_W
`define UART_FIFO_COUNTER_W 5
`endif

module cmd_frame_tx #(
  parameter int unsigned TX_FIFO_DEPTH = 16,
  parameter int unsigned PUSH_GAP      = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [7:0]                      req_addr,
  input  logic [7:0]                      req_cmd,
  input  logic [`UART_FIFO_COUNTER_W-1:0] tf_counter,
  output logic                            tf_push,
  output logic [7:0]                      tdr,
  output logic                            busy,
  output logic                            done,
  output logic [7:0]                      seq_num
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SPACE,
    S_PUSH,
    S_GAP,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  gap_q, gap_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  chk_q, chk_d;
  logic        req_ready_q, req_ready_d;
  logic        tf_push_q, tf_push_d;
  logic [7:0]  tdr_q, tdr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  seq_val;
  logic [7:0]  cur_byte;
  logic        space_ok;

`ifdef CMD_TX_SEQ_EN
  logic [7:0] seq_q, seq_d;
  assign seq_val = seq_q;
`else
  assign seq_val = 8'h00;
`endif

  // seq_val only changes on entry to DONE, so byte 2 is read live rather than latched.
  always_comb begin
    cur_byte = 8'h00;
    case (idx_q)
      3'd0:    cur_byte = 8'hEB;
      3'd1:    cur_byte = 8'h90;
      3'd2:    cur_byte = seq_val;
      3'd3:    cur_byte = addr_q;
      3'd4:    cur_byte = cmd_q;
      3'd5:    cur_byte = chk_q;
      3'd6:    cur_byte = 8'h09;
      default: cur_byte = 8'hD7;
    endcase
  end

  assign space_ok = (32'(tf_counter) + 32'd8) <= TX_FIFO_DEPTH;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    addr_d    = addr_q;
    cmd_d     = cmd_q;
    chk_d     = chk_q;
    tdr_d     = tdr_q;
    tf_push_d = 1'b0;
`ifdef CMD_TX_SEQ_EN
    seq_d     = seq_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d  = req_addr;
          cmd_d   = req_cmd;
          chk_d   = 8'h00 - (seq_val + req_addr + req_cmd);
          idx_d   = '0;
          state_d = S_WAIT_SPACE;
        end
      end
      S_WAIT_SPACE: begin
        if (space_ok) state_d = S_PUSH;
      end
      S_PUSH: begin
        tf_push_d = 1'b1;
        tdr_d     = cur_byte;
        gap_d     = '0;
        state_d   = S_GAP;
      end
      S_GAP: begin
        if (gap_q == 4'(PUSH_GAP - 1)) begin
          if (idx_q == 3'd7) begin
            state_d = S_DONE;
`ifdef CMD_TX_SEQ_EN
            seq_d   = seq_q + 8'd1;
`endif
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_PUSH;
          end
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered from the next state so they line up with the state they describe.
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d == S_WAIT_SPACE) || (state_d == S_PUSH) || (state_d == S_GAP);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      gap_q       <= '0;
      addr_q      <= '0;
      cmd_q       <= '0;
      chk_q       <= '0;
      req_ready_q <= 1'b0;
      tf_push_q   <= 1'b0;
      tdr_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef CMD_TX_SEQ_EN
      seq_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      addr_q      <= addr_d;
      cmd_q       <= cmd_d;
      chk_q       <= chk_d;
      req_ready_q <= req_ready_d;
      tf_push_q   <= tf_push_d;
      tdr_q       <= tdr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef CMD_TX_SEQ_EN
      seq_q       <= seq_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign tf_push   = tf_push_q;
  assign tdr       = tdr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign seq_num   = seq_val;

endmodule

// File: tb/tb_cmd_frame_tx.sv
// Scoreboard bench for cmd_frame_tx (PUSH_GAP=3, TX_FIFO_DEPTH=16); follows CMD_TX_SEQ_EN if defined.
`ifndef UART_FIFO_COUNTER_W
`define UART_FIFO_COUNTER_W 5
`endif

module tb_cmd_frame_tx;
  localparam int unsigned GAP = 3;

  logic                            clk = 1'b0;
  logic                            rst = 1'b1;
  logic                            req_valid = 1'b0;
  logic                            req_ready;
  logic [7:0]                      req_addr = 8'h00;
  logic [7:0]                      req_cmd = 8'h00;
  logic [`UART_FIFO_COUNTER_W-1:0] tf_counter = '0;
  logic                            tf_push;
  logic [7:0]                      tdr;
  logic                            busy;
  logic                            done;
  logic [7:0]                      seq_num;

  cmd_frame_tx #(.TX_FIFO_DEPTH(16), .PUSH_GAP(GAP)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_cmd(req_cmd), .tf_counter(tf_counter),
    .tf_push(tf_push), .tdr(tdr), .busy(busy), .done(done), .seq_num(seq_num)
  );

  always #5 clk = ~clk;

  int        cyc = 0;
  int        total = 0;
  int        bad = 0;
  logic [7:0] sb[$];
  logic [7:0] model_seq = 8'h00;
  int        exp_first = 0;
  int        last_push = 0;
  int        push_idx = 0;
  int        pushes_total = 0;
  int        frames = 0;
  logic      done_prev = 1'b0;
  logic [7:0] last_tdr = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: pops expected bytes on every push and checks spacing, done timing and seq_num.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      push_idx  = 0;
      done_prev = 1'b0;
    end else begin
      if (done_prev) check("done_one_cycle", {31'd0, done}, 32'd0);
      done_prev = done;
      if (tf_push) begin
        if (sb.size() == 0) check("extra_push", 32'd1, 32'd0);
        else check("tdr", {24'd0, tdr}, {24'd0, sb.pop_front()});
        if (push_idx == 0) check("first_push_lat", cyc, exp_first);
        else check("push_spacing", cyc - last_push, GAP + 1);
        last_push = cyc;
        last_tdr  = tdr;
        push_idx++;
        pushes_total++;
      end else if (push_idx > 0) begin
        check("tdr_hold", {24'd0, tdr}, {24'd0, last_tdr});
      end
      if (done) begin
        check("done_after_8", push_idx, 8);
        check("done_lat", cyc - last_push, GAP);
        check("seq_num_after_done", {24'd0, seq_num}, {24'd0, model_seq});
        push_idx = 0;
        frames++;
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] c);
    logic       ok;
    logic [7:0] b2;
    logic [7:0] chk;
    ok = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    req_cmd   = c;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (req_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end else begin
        if (busy) check("ready_low_while_busy", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
      end
    end
    req_valid = 1'b0;
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
`ifdef CMD_TX_SEQ_EN
      b2 = model_seq;
      model_seq = model_seq + 8'd1;
`else
      b2 = 8'h00;
`endif
      chk = 8'h00 - (b2 + a + c);
      sb.push_back(8'hEB); sb.push_back(8'h90); sb.push_back(b2);  sb.push_back(a);
      sb.push_back(c);     sb.push_back(chk);   sb.push_back(8'h09); sb.push_back(8'hD7);
      exp_first = cyc + 2;
      @(negedge clk);
      check("busy_after_accept", {31'd0, busy}, 32'd1);
      check("ready_after_accept", {31'd0, req_ready}, 32'd0);
    end
  endtask

  task automatic wait_frames(input int target);
    for (int i = 0; i < 400 && frames < target; i++) @(negedge clk);
    if (frames < target) check("frame_timeout", frames, target);
  endtask

  task automatic idle_no_push(input int n, input string tag);
    int p0;
    p0 = pushes_total;
    repeat (n) @(negedge clk);
    check(tag, pushes_total - p0, 0);
  endtask

  initial begin
    int p0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_tf_push", {31'd0, tf_push}, 32'd0);
    check("rst_tdr", {24'd0, tdr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_seq", {24'd0, seq_num}, 32'd0);
    rst = 1'b0;

    // Frames 1 and 2 back to back
    send(8'hAB, 8'h0A);
    send(8'hAB, 8'h0B);
    wait_frames(2);

    // Insufficient FIFO space holds the frame until 8 bytes are free
    tf_counter = 9;
    send(8'h12, 8'h34);
    idle_no_push(10, "no_push_without_space");
    check("busy_waiting_space", {31'd0, busy}, 32'd1);
    tf_counter = 8;
    exp_first = cyc + 2;
    wait_frames(3);
    tf_counter = 0;

`ifdef CMD_TX_SEQ_EN
    // Walk the counter up to FF and check the wrap
    for (int i = 0; i < 300 && model_seq != 8'hFF; i++) begin
      send(8'(i), 8'(i * 7));
      wait_frames(frames + 1);
    end
    check("seq_at_ff", {24'd0, seq_num}, 32'hFF);
    send(8'hAB, 8'h0A);
    wait_frames(frames + 1);
    check("seq_wrapped", {24'd0, seq_num}, 32'h00);
`endif

    // Reset mid-frame after the third byte
    send(8'h55, 8'hC3);
    p0 = pushes_total;
    for (int i = 0; i < 100 && pushes_total - p0 < 3; i++) @(negedge clk);
    check("three_bytes_before_rst", pushes_total - p0, 3);
    rst = 1'b1;
    model_seq = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("midrst_tf_push", {31'd0, tf_push}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_seq", {24'd0, seq_num}, 32'd0);
    rst = 1'b0;
    idle_no_push(12, "no_push_after_rst");
    send(8'hAB, 8'h0A);
    wait_frames(frames + 1);

    // Same request twice (identical frames when the sequence counter is absent)
    send(8'hAB, 8'hA0);
    wait_frames(frames + 1);
    send(8'hAB, 8'hA0);
    wait_frames(frames + 1);

    idle_no_push(10, "quiet_at_end");
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
